// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller: state encoding,
// key bit positions, coin values and the key priority decoder.
package vend_pkg;

    localparam int CREDIT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam int KEY_C05 = 0;
    localparam int KEY_C10 = 1;
    localparam int KEY_BUY = 2;
    localparam int KEY_CAN = 3;

    localparam logic [CREDIT_W-1:0] COIN_C05_VAL = 5'd1;
    localparam logic [CREDIT_W-1:0] COIN_C10_VAL = 5'd2;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_C05  = 3'd1,
        ACT_C10  = 3'd2,
        ACT_BUY  = 3'd3,
        ACT_CAN  = 3'd4
    } key_act_t;

    // Keep only the highest-priority key: cancel > buy > coin 1.0 > coin 0.5.
    function automatic key_act_t decode_key(input logic [3:0] keys);
        key_act_t act;
        if (keys[KEY_CAN])      act = ACT_CAN;
        else if (keys[KEY_BUY]) act = ACT_BUY;
        else if (keys[KEY_C10]) act = ACT_C10;
        else if (keys[KEY_C05]) act = ACT_C05;
        else                    act = ACT_NONE;
        return act;
    endfunction

    // Credit value of a coin action; zero for anything that is not a coin.
    function automatic logic [CREDIT_W-1:0] coin_value(input key_act_t act);
        logic [CREDIT_W-1:0] val;
        case (act)
            ACT_C05: val = COIN_C05_VAL;
            ACT_C10: val = COIN_C10_VAL;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
// Loading N makes done rise N cycles after the load edge.
module vend_timer #(
    parameter int W = 10
) (
    input  logic         clk1k,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk1k) begin
        if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, grants a purchase with a
// timed vend output, and returns remaining credit as paced change pulses.
// Optional auto-refund after inactivity in CREDIT: define VEND_AUTO_REFUND_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 20,
    parameter int VEND_CYC   = 1000,
    parameter int CHG_GAP    = 200
`ifdef VEND_AUTO_REFUND_EN
    ,
    parameter int TIMEOUT_CYC = 10000
`endif
) (
    input  logic                clk1k,
    input  logic                clr,
    input  logic [3:0]          key_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_pulse,
    output logic                busy,
    output logic                reject
);

    localparam int VEND_W = $clog2(VEND_CYC + 1);
    localparam int GAP_W  = $clog2(CHG_GAP + 1);

    // Timers are loaded one less than the period because the action fires on
    // the edge after done is seen.
    localparam logic [VEND_W-1:0]   VEND_LOAD = VEND_W'(VEND_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LOAD  = GAP_W'(CHG_GAP - 1);
    localparam logic [CREDIT_W-1:0] PRICE_VAL = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                vend_reg, vend_next;
    logic                change_pulse_reg, change_pulse_next;
    logic                busy_reg, busy_next;
    logic                reject_reg, reject_next;

    key_act_t            act;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                is_coin;
    logic                go_change;
    logic                vend_load, vend_done;
    logic                gap_load, gap_done;

    vend_timer #(.W(VEND_W)) u_vend_timer (
        .clk1k    (clk1k),
        .clr      (clr),
        .load     (vend_load),
        .load_val (VEND_LOAD),
        .done     (vend_done)
    );

    vend_timer #(.W(GAP_W)) u_gap_timer (
        .clk1k    (clk1k),
        .clr      (clr),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .done     (gap_done)
    );

`ifdef VEND_AUTO_REFUND_EN
    localparam int                REF_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [REF_W-1:0]  REF_LOAD = REF_W'(TIMEOUT_CYC - 1);

    logic refund_load, refund_done;

    // Restart the inactivity window on every key and whenever we are not in CREDIT.
    assign refund_load = (key_pulse != 4'd0) || (state_reg != ST_CREDIT);

    vend_timer #(.W(REF_W)) u_refund_timer (
        .clk1k    (clk1k),
        .clr      (clr),
        .load     (refund_load),
        .load_val (REF_LOAD),
        .done     (refund_done)
    );
`endif

    // Next-state, credit arithmetic and output pulses.
    always_comb begin
        act        = decode_key(key_pulse);
        coin_val   = coin_value(act);
        is_coin    = (act == ACT_C05) || (act == ACT_C10);
        credit_sum = {1'b0, credit_reg} + {1'b0, coin_val};

        state_next        = state_reg;
        credit_next       = credit_reg;
        vend_next         = vend_reg;
        change_pulse_next = 1'b0;
        reject_next       = 1'b0;
        vend_load         = 1'b0;
        gap_load          = 1'b0;
        go_change         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (act == ACT_BUY) begin
                    reject_next = 1'b1;
                end else if (is_coin) begin
                    credit_next = credit_sum[CREDIT_W-1:0];
                    state_next  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (act == ACT_CAN) begin
                    go_change = 1'b1;
                end else if (act == ACT_BUY) begin
                    if (credit_reg >= PRICE_VAL) begin
                        credit_next = credit_reg - PRICE_VAL;
                        vend_next   = 1'b1;
                        vend_load   = 1'b1;
                        state_next  = ST_VEND;
                    end else begin
                        reject_next = 1'b1;
                    end
                end else if (is_coin) begin
                    if (credit_sum > MAX_EXT) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                    end
                end
`ifdef VEND_AUTO_REFUND_EN
                else if (refund_done) begin
                    go_change = 1'b1;
                end
`endif
            end
            ST_VEND: begin
                if (is_coin || act == ACT_BUY) begin
                    reject_next = 1'b1;
                end
                if (vend_done) begin
                    vend_next = 1'b0;
                    if (credit_reg != '0) begin
                        go_change = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                if (is_coin || act == ACT_BUY) begin
                    reject_next = 1'b1;
                end
                if (credit_reg == '0) begin
                    state_next = ST_IDLE;
                end else if (gap_done) begin
                    change_pulse_next = 1'b1;
                    credit_next       = credit_reg - CREDIT_W'(1);
                    gap_load          = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Entering CHANGE pays the first coin immediately and starts the gap timer.
        if (go_change) begin
            state_next        = ST_CHANGE;
            change_pulse_next = 1'b1;
            credit_next       = credit_reg - CREDIT_W'(1);
            gap_load          = 1'b1;
        end

        busy_next = (state_next == ST_VEND) || (state_next == ST_CHANGE);
    end

    // State and registered outputs.
    always_ff @(posedge clk1k) begin
        if (clr) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            vend_reg         <= 1'b0;
            change_pulse_reg <= 1'b0;
            busy_reg         <= 1'b0;
            reject_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            vend_reg         <= vend_next;
            change_pulse_reg <= change_pulse_next;
            busy_reg         <= busy_next;
            reject_reg       <= reject_next;
        end
    end

    assign credit       = credit_reg;
    assign vend         = vend_reg;
    assign change_pulse = change_pulse_reg;
    assign busy         = busy_reg;
    assign reject       = reject_reg;

endmodule
